receiver: RTL



---
 rtl/receiver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/receiver.sv
// receiver: 8N1 serial byte receiver with valid/ack hold handshake.
// Line rx is double-flopped, a frame is timed with a fixed CLKS_PER_BIT
// count, and each completed byte is held on data until the consumer acks.
// Optional build macro: RECEIVER_MAJORITY_EN -- when defined, every bit
// evaluation takes a 2-of-3 vote over the last three synchronized samples,
// rejecting single-cycle glitches. Edge timing is identical either way.
module receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Evaluation points: mid start bit, then one full bit period each.
    localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] BIT_M1  = 8'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 255) begin : g_bad_cpb
        $error("receiver: CLKS_PER_BIT must be in 4..255");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;
    logic       rx_meta;
    logic       rx_s;
    logic       sample;
    logic       stop_eval;
    logic       stop_ok;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef RECEIVER_MAJORITY_EN
    // Two previous synchronized samples; with rx_s they form the 3-deep window.
    logic [1:0] hist;
    logic [2:0] win;

    // History of rx_s from the two preceding edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign win    = {hist, rx_s};
    assign sample = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
`else
    assign sample = rx_s;
`endif

    assign stop_eval = (state == STOP) && (cnt == BIT_M1);
    assign stop_ok   = stop_eval && sample;

    // Frame sequencer: start qualification, data shifting, stop check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            idx       <= 3'd0;
            shift     <= 8'd0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= 8'd0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= 8'd0;
                        if (sample) begin
                            // Line went back high: false start, drop quietly.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt        <= 8'd0;
                        shift[idx] <= sample;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt <= 8'd0;
                        if (sample) begin
                            // Back to IDLE half a bit early so a tight
                            // back-to-back start edge is not missed.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low (break) line must not look like a new start.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Consumer handshake: deliver on a good stop, clear on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= 8'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (stop_ok) begin
            if (!valid || ack) begin
                // Slot free (or being freed this cycle); overrun untouched.
                data  <= shift;
                valid <= 1'b1;
            end else begin
                // Consumer still holds the old byte: keep it, drop the new one.
                overrun <= 1'b1;
            end
        end else if (ack && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
